config_frame_loader: RTL and testbench
======================================

CONFIG_FRAME_LOADER -- requirements
Module: config_frame_loader

Interface
REQ-001 Parameter NUM_BYTES, default 7, number of bytes in one configuration frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, idle cycles inside a frame before the partial frame is discarded.
REQ-003 clk  input  1  single system clock, all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe marking rx_data valid.
REQ-007 cfg_clear  input  1  synchronous request to abort any frame and invalidate the configuration.
REQ-008 cfg_out  output  8*NUM_BYTES  committed configuration vector for the logic-cell fabric.
REQ-009 cfg_valid  output  1  high while cfg_out holds a complete committed frame.
REQ-010 cfg_commit  output  1  one-cycle pulse when cfg_out is updated.
REQ-011 busy  output  1  high while a frame is partially received.
REQ-012 frame_err  output  1  one-cycle pulse when a partial frame is discarded by timeout.
REQ-013 frame_count  output  8  number of committed frames, saturating at 255.

Function
REQ-014 The FSM SHALL have the states IDLE, RECV and COMMIT.
REQ-015 In IDLE, rx_valid SHALL load rx_data into the assembly register, set byte_cnt=1 and enter RECV. If NUM_BYTES=1, it SHALL enter COMMIT directly.
REQ-016 In RECV, each rx_valid SHALL shift the assembly register left 8 bits, insert rx_data at bits [7:0] and increment byte_cnt. The first byte received SHALL end at bits [8*NUM_BYTES-1 -: 8] (MSB byte first).
REQ-017 When the byte making byte_cnt=NUM_BYTES is sampled at edge N, the FSM SHALL enter COMMIT. At edge N+1, cfg_out SHALL be loaded with the assembly register, cfg_valid SHALL be set, cfg_commit SHALL go high and frame_count SHALL increment. cfg_commit SHALL be low again after edge N+2.
REQ-018 In COMMIT, an rx_valid SHALL be accepted as byte 1 of the next frame (next state RECV, byte_cnt=1). Without rx_valid, the next state SHALL be IDLE. No byte SHALL be lost.
REQ-019 cfg_out SHALL change only on a commit. A partial or aborted frame SHALL never alter cfg_out or cfg_valid.
REQ-020 In RECV, a timeout counter SHALL clear on every rx_valid and increment on every cycle without rx_valid. On reaching TIMEOUT_CYCLES it SHALL:
 - pulse frame_err for one cycle;
 - clear byte_cnt;
 - enter IDLE.
REQ-021 If rx_valid coincides with the timeout cycle, the byte SHALL win: it is accepted and the counter clears, with no frame_err.
REQ-022 cfg_clear SHALL take priority over rx_valid and the timeout. On the next edge it SHALL:
 - clear cfg_valid, cfg_out, byte_cnt and the timeout counter;
 - enter IDLE.
 It SHALL not pulse frame_err or cfg_commit, and frame_count SHALL be unchanged.
REQ-023 busy SHALL be high exactly when the state is RECV.
REQ-024 byte_cnt SHALL be ceil(log2(NUM_BYTES+1)) bits wide. The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL not wrap.
REQ-025 frame_count SHALL hold at 255 once reached; commits still occur.

Reset
REQ-026 While rst_n=0, the block SHALL immediately force:
 - state to IDLE;
 - cfg_out=0, cfg_valid=0, cfg_commit=0;
 - busy=0, frame_err=0, frame_count=0;
 - byte_cnt=0, timeout counter=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no frame_err. After release, the next byte SHALL be treated as byte 1.
REQ-028 The first rising edge after rst_n deasserts SHALL be able to sample rx_valid.

Verification
REQ-029 Single frame: bytes 0x01..0x07 with 176-cycle spacing -> cfg_out=0x01020304050607, cfg_valid=1, one cfg_commit pulse one cycle after the 7th byte, frame_count=1.
REQ-030 Back-to-back: second frame 0xA0..0xA6 with byte 1 arriving in the COMMIT cycle -> cfg_out=0xA0A1A2A3A4A5A6, frame_count=2, no frame_err.
REQ-031 Timeout: 3 bytes, then silence for TIMEOUT_CYCLES -> one frame_err pulse, busy=0, cfg_out unchanged. A following full frame 0x11..0x17 commits as 0x11121314151617.
REQ-032 Timeout race: byte arrives exactly in the timeout cycle -> no frame_err, byte_cnt increments.
REQ-033 Clear: 4 bytes then cfg_clear=1 for one cycle, simultaneous with rx_valid -> cfg_valid=0, cfg_out=0, busy=0, that byte dropped.
REQ-034 Reset: rst_n low after 5 bytes, then released, then 7 bytes 0x21..0x27 -> cfg_out=0x21222324252627, frame_count=1.

Source files
------------

// File: rtl/config_frame_loader_if.sv
// Byte-in / configuration-out bundle for config_frame_loader.
// The master side feeds received bytes and clear requests; the slave side is the loader.
interface config_frame_loader_if #(
  parameter int NUM_BYTES = 7
);
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   cfg_clear;
  logic [8*NUM_BYTES-1:0] cfg_out;
  logic                   cfg_valid;
  logic                   cfg_commit;
  logic                   busy;
  logic                   frame_err;
  logic [7:0]             frame_count;

  // rx_valid is a one-cycle strobe with no back-pressure: every strobed byte is
  // either accepted or deliberately dropped (cfg_clear), never stalled.
  modport master (
    output rx_data, rx_valid, cfg_clear,
    input  cfg_out, cfg_valid, cfg_commit, busy, frame_err, frame_count
  );

  modport slave (
    input  rx_data, rx_valid, cfg_clear,
    output cfg_out, cfg_valid, cfg_commit, busy, frame_err, frame_count
  );
endinterface

// File: rtl/config_frame_loader.sv
// Assembles NUM_BYTES serial bytes (MSB byte first) into a configuration frame and
// commits it atomically to cfg_out; partial frames time out or are aborted without effect.
module config_frame_loader #(
  parameter int NUM_BYTES      = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                clk,
  input  logic                                rst_n,
  config_frame_loader_if.slave                bus,
  output logic [1:0]                          state_dbg,
  output logic [$clog2(NUM_BYTES+1)-1:0]      byte_cnt_dbg,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] timeout_cnt_dbg
);

  localparam int W   = 8 * NUM_BYTES;
  localparam int BCW = $clog2(NUM_BYTES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RECV   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [BCW-1:0] LAST_CNT = BCW'(NUM_BYTES);
  localparam logic [BCW-1:0] ONE_CNT  = BCW'(1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]     FIRST_NEXT = (NUM_BYTES == 1) ? COMMIT : RECV;

  logic [1:0]     state_q,       state_d;
  logic [BCW-1:0] byte_cnt_q,    byte_cnt_d;
  logic [TCW-1:0] to_cnt_q,      to_cnt_d;
  logic [W-1:0]   asm_q,         asm_d;
  logic [W-1:0]   cfg_out_q,     cfg_out_d;
  logic           cfg_valid_q,   cfg_valid_d;
  logic           cfg_commit_q,  cfg_commit_d;
  logic           frame_err_q,   frame_err_d;
  logic [7:0]     frame_count_q, frame_count_d;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    to_cnt_d      = to_cnt_q;
    asm_d         = asm_q;
    cfg_out_d     = cfg_out_q;
    cfg_valid_d   = cfg_valid_q;
    cfg_commit_d  = 1'b0;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;

    if (bus.cfg_clear) begin
      state_d     = IDLE;
      byte_cnt_d  = '0;
      to_cnt_d    = '0;
      asm_d       = '0;
      cfg_out_d   = '0;
      cfg_valid_d = 1'b0;
    end else begin
      // The commit is independent of the byte path, so a byte arriving in the
      // COMMIT cycle starts the next frame while the finished one is published.
      if (state_q == COMMIT) begin
        cfg_out_d    = asm_q;
        cfg_valid_d  = 1'b1;
        cfg_commit_d = 1'b1;
        if (frame_count_q != 8'hFF) begin
          frame_count_d = frame_count_q + 8'd1;
        end
      end

      case (state_q)
        IDLE, COMMIT: begin
          to_cnt_d = '0;
          if (bus.rx_valid) begin
            asm_d      = W'(bus.rx_data);
            byte_cnt_d = ONE_CNT;
            state_d    = FIRST_NEXT;
          end else begin
            byte_cnt_d = '0;
            state_d    = IDLE;
          end
        end

        RECV: begin
          // A byte in the timeout cycle wins over the timeout.
          if (bus.rx_valid) begin
            asm_d      = (asm_q << 8) | W'(bus.rx_data);
            byte_cnt_d = byte_cnt_q + ONE_CNT;
            to_cnt_d   = '0;
            if (byte_cnt_q == LAST_CNT - ONE_CNT) begin
              state_d = COMMIT;
            end
          end else if (to_cnt_q == TO_LAST) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            to_cnt_d    = '0;
            state_d     = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TCW'(1);
          end
        end

        default: begin
          state_d    = IDLE;
          byte_cnt_d = '0;
          to_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      to_cnt_q      <= '0;
      asm_q         <= '0;
      cfg_out_q     <= '0;
      cfg_valid_q   <= 1'b0;
      cfg_commit_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      to_cnt_q      <= to_cnt_d;
      asm_q         <= asm_d;
      cfg_out_q     <= cfg_out_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_commit_q  <= cfg_commit_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign bus.cfg_out     = cfg_out_q;
  assign bus.cfg_valid   = cfg_valid_q;
  assign bus.cfg_commit  = cfg_commit_q;
  assign bus.busy        = (state_q == RECV);
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_count = frame_count_q;

  assign state_dbg       = state_q;
  assign byte_cnt_dbg    = byte_cnt_q;
  assign timeout_cnt_dbg = to_cnt_q;

endmodule

// File: tb/tb_config_frame_loader.sv
// Directed bench for config_frame_loader: single frame, back-to-back, timeout,
// timeout race, clear, mid-frame reset and frame_count saturation.
module tb_config_frame_loader;

  localparam int NB = 7;
  localparam int TO = 1024;
  localparam int W  = 8 * NB;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic        clk;
  logic        rst_n;
  logic [1:0]  state_dbg;
  logic [2:0]  byte_cnt_dbg;
  logic [10:0] timeout_cnt_dbg;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  config_frame_loader_if #(.NUM_BYTES(NB)) bus();

  config_frame_loader #(
    .NUM_BYTES(NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg),
    .byte_cnt_dbg(byte_cnt_dbg),
    .timeout_cnt_dbg(timeout_cnt_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // monitor: record every committed frame and every frame_err pulse
  always @(negedge clk) begin
    if (bus.cfg_commit === 1'b1) got_q.push_back(bus.cfg_out);
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; byte is sampled at the following posedge
  task automatic put_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    logic [7:0]   b;

    rst_n         = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.cfg_clear = 1'b0;
    idle(3);

    chk("rst_cfg_out",     64'(bus.cfg_out),     64'(0));
    chk("rst_cfg_valid",   64'(bus.cfg_valid),   64'(0));
    chk("rst_cfg_commit",  64'(bus.cfg_commit),  64'(0));
    chk("rst_busy",        64'(bus.busy),        64'(0));
    chk("rst_frame_err",   64'(bus.frame_err),   64'(0));
    chk("rst_frame_count", 64'(bus.frame_count), 64'(0));
    chk("rst_state",       64'(state_dbg),       64'(S_IDLE));
    chk("rst_byte_cnt",    64'(byte_cnt_dbg),    64'(0));
    rst_n = 1'b1;

    // single frame, 176-cycle byte spacing
    exp_q.push_back(56'h01020304050607);
    put_byte(8'h01);
    chk("f1_busy_after_b1", 64'(bus.busy),     64'(1));
    chk("f1_cnt_after_b1",  64'(byte_cnt_dbg), 64'(1));
    idle(175);
    chk("f1_timeout_cnt",   64'(timeout_cnt_dbg), 64'(175));
    for (int i = 2; i <= 6; i++) begin
      put_byte(8'(i));
      idle(175);
    end
    put_byte(8'h07);
    chk("f1_state_commit",   64'(state_dbg),      64'(S_COMMIT));
    chk("f1_commit_not_yet", 64'(bus.cfg_commit), 64'(0));
    chk("f1_valid_not_yet",  64'(bus.cfg_valid),  64'(0));

    // back-to-back: byte 1 of the next frame lands in the COMMIT cycle
    exp_q.push_back(56'hA0A1A2A3A4A5A6);
    put_byte(8'hA0);
    chk("f1_commit_pulse", 64'(bus.cfg_commit),  64'(1));
    chk("f1_cfg_out",      64'(bus.cfg_out),     64'h01020304050607);
    chk("f1_cfg_valid",    64'(bus.cfg_valid),   64'(1));
    chk("f1_frame_count",  64'(bus.frame_count), 64'(1));
    chk("f2_state_recv",   64'(state_dbg),       64'(S_RECV));
    chk("f2_cnt_b1",       64'(byte_cnt_dbg),    64'(1));
    for (int i = 1; i <= 6; i++) put_byte(8'hA0 + 8'(i));
    idle(1);
    chk("f2_commit_pulse", 64'(bus.cfg_commit),  64'(1));
    chk("f2_cfg_out",      64'(bus.cfg_out),     64'hA0A1A2A3A4A5A6);
    chk("f2_frame_count",  64'(bus.frame_count), 64'(2));
    idle(1);
    chk("f2_commit_low",   64'(bus.cfg_commit),  64'(0));
    chk("f2_state_idle",   64'(state_dbg),       64'(S_IDLE));
    chk("f2_no_err",       64'(err_cnt),         64'(0));

    // timeout after 3 bytes
    idle(3);
    put_byte(8'h11);
    put_byte(8'h12);
    put_byte(8'h13);
    idle(TO - 1);
    chk("to_busy_before",  64'(bus.busy),        64'(1));
    chk("to_err_before",   64'(bus.frame_err),   64'(0));
    chk("to_cnt_before",   64'(timeout_cnt_dbg), 64'(TO - 1));
    idle(1);
    chk("to_err_pulse",    64'(bus.frame_err),   64'(1));
    chk("to_busy_after",   64'(bus.busy),        64'(0));
    chk("to_byte_cnt",     64'(byte_cnt_dbg),    64'(0));
    chk("to_cfg_out_kept", 64'(bus.cfg_out),     64'hA0A1A2A3A4A5A6);
    chk("to_valid_kept",   64'(bus.cfg_valid),   64'(1));
    idle(1);
    chk("to_err_low",      64'(bus.frame_err),   64'(0));
    chk("to_err_count",    64'(err_cnt),         64'(1));
    exp_q.push_back(56'h11121314151617);
    for (int i = 0; i < 7; i++) put_byte(8'h11 + 8'(i));
    idle(1);
    chk("f3_cfg_out",      64'(bus.cfg_out),     64'h11121314151617);
    chk("f3_frame_count",  64'(bus.frame_count), 64'(3));

    // timeout race: byte sampled in the timeout cycle wins
    idle(2);
    put_byte(8'h31);
    put_byte(8'h32);
    put_byte(8'h33);
    idle(TO - 1);
    chk("race_cnt_before", 64'(timeout_cnt_dbg), 64'(TO - 1));
    put_byte(8'h34);
    chk("race_no_err",     64'(bus.frame_err),   64'(0));
    chk("race_byte_cnt",   64'(byte_cnt_dbg),    64'(4));
    chk("race_busy",       64'(bus.busy),        64'(1));
    chk("race_to_cleared", 64'(timeout_cnt_dbg), 64'(0));
    exp_q.push_back(56'h31323334353637);
    put_byte(8'h35);
    put_byte(8'h36);
    put_byte(8'h37);
    idle(1);
    chk("f4_cfg_out",      64'(bus.cfg_out),     64'h31323334353637);
    chk("f4_frame_count",  64'(bus.frame_count), 64'(4));
    idle(1);
    chk("race_err_count",  64'(err_cnt),         64'(1));

    // clear mid-frame, coinciding with a byte
    idle(2);
    for (int i = 0; i < 4; i++) put_byte(8'h41 + 8'(i));
    bus.cfg_clear = 1'b1;
    put_byte(8'h45);
    bus.cfg_clear = 1'b0;
    chk("clr_cfg_valid",   64'(bus.cfg_valid),   64'(0));
    chk("clr_cfg_out",     64'(bus.cfg_out),     64'(0));
    chk("clr_busy",        64'(bus.busy),        64'(0));
    chk("clr_byte_cnt",    64'(byte_cnt_dbg),    64'(0));
    chk("clr_frame_count", 64'(bus.frame_count), 64'(4));
    chk("clr_no_commit",   64'(bus.cfg_commit),  64'(0));
    chk("clr_no_err",      64'(bus.frame_err),   64'(0));
    idle(1);
    chk("clr_err_count",   64'(err_cnt),         64'(1));

    // reset mid-frame after 5 bytes
    for (int i = 0; i < 5; i++) put_byte(8'h51 + 8'(i));
    rst_n = 1'b0;
    #1;
    chk("mrst_busy",        64'(bus.busy),        64'(0));
    chk("mrst_byte_cnt",    64'(byte_cnt_dbg),    64'(0));
    chk("mrst_frame_count", 64'(bus.frame_count), 64'(0));
    chk("mrst_cfg_out",     64'(bus.cfg_out),     64'(0));
    idle(2);
    rst_n = 1'b1;
    exp_q.push_back(56'h21222324252627);
    for (int i = 0; i < 7; i++) put_byte(8'h21 + 8'(i));
    idle(1);
    chk("f5_cfg_out",      64'(bus.cfg_out),     64'h21222324252627);
    chk("f5_cfg_valid",    64'(bus.cfg_valid),   64'(1));
    chk("f5_frame_count",  64'(bus.frame_count), 64'(1));
    chk("f5_err_count",    64'(err_cnt),         64'(1));
    idle(1);

    // 255 more frames back-to-back: frame_count saturates, commits continue
    v = '0;
    for (int f = 0; f < 255; f++) begin
      for (int j = 0; j < NB; j++) begin
        b = 8'(f + 16 * j);
        v = {v[W-9:0], b};
        put_byte(b);
      end
      exp_q.push_back(v);
    end
    idle(1);
    chk("sat_frame_count", 64'(bus.frame_count), 64'(255));
    chk("sat_cfg_out",     64'(bus.cfg_out),     64'(v));
    chk("sat_commit",      64'(bus.cfg_commit),  64'(1));
    idle(2);

    // scoreboard: every commit in order, no extras
    chk("sb_commit_count", 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      chk("sb_frame", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
